// File: rtl/multi_cycle_control_fsm_if.sv
// multi_cycle_control_fsm_if: control bundle between the TSC main control FSM and the datapath.
//   opcode/funct/input_ready : instruction fields and memory-done handshake into the FSM
//   ALUOp ... output_valid   : datapath enables, mux selects and memory strobes
//   is_halted, num_inst      : sticky halt flag and retired-instruction count
// Modports: master = control FSM, slave = datapath/memory side.
interface multi_cycle_control_fsm_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [3:0]       opcode;
  logic [5:0]       funct;
  logic             input_ready;
  logic             ALUOp;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             output_valid;
  logic             is_halted;
  logic [CNT_W-1:0] num_inst;

  modport master (
    input  opcode, funct, input_ready,
    output ALUOp, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
    output reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, output_valid, is_halted,
    output num_inst
  );

  modport slave (
    output opcode, funct, input_ready,
    input  ALUOp, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
    input  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, output_valid, is_halted,
    input  num_inst
  );
endinterface

// File: rtl/multi_cycle_control_fsm.sv
// multi_cycle_control_fsm: multi-cycle main control for the TSC CPU.
// Sequences IF/ID/EX/MEM/WB (plus absorbing HALT), drives every datapath enable/select and
// handshakes with memory through input_ready.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : multi_cycle_control_fsm_if.master (instruction fields in, controls out)
// Build option: define CTRL_INST_COUNT_EN to include the retired-instruction counter;
// otherwise num_inst is tied to 0.
module multi_cycle_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input logic                       clk,
  input logic                       reset_n,
  multi_cycle_control_fsm_if.master bus
);

  localparam logic [3:0] OpBne = 4'd0;
  localparam logic [3:0] OpBeq = 4'd1;
  localparam logic [3:0] OpBgz = 4'd2;
  localparam logic [3:0] OpBlz = 4'd3;
  localparam logic [3:0] OpAdi = 4'd4;
  localparam logic [3:0] OpOri = 4'd5;
  localparam logic [3:0] OpLhi = 4'd6;
  localparam logic [3:0] OpLwd = 4'd7;
  localparam logic [3:0] OpSwd = 4'd8;
  localparam logic [3:0] OpJmp = 4'd9;
  localparam logic [3:0] OpJal = 4'd10;
  localparam logic [3:0] OpAlu = 4'd15;

  localparam logic [5:0] FnShr = 6'd7;  // functs 0..7 are the R-type ALU ops
  localparam logic [5:0] FnJpr = 6'd25;
  localparam logic [5:0] FnJrl = 6'd26;
  localparam logic [5:0] FnWwd = 6'd28;
  localparam logic [5:0] FnHlt = 6'd29;

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  typedef enum logic [3:0] {
    IcNop, IcRtype, IcAdi, IcOri, IcLwd, IcSwd, IcBranch,
    IcJmp, IcJal, IcJpr, IcJrl, IcWwd, IcHlt
  } iclass_e;

  state_e     state_q;
  logic [3:0] op_q;
  logic [5:0] fn_q;
  iclass_e    iclass;

  // Instruction class from the latched IR fields, so later input changes cannot leak in.
  always_comb begin
    iclass = IcNop;
    case (op_q)
      OpBne, OpBeq, OpBgz, OpBlz: iclass = IcBranch;
      OpAdi:                      iclass = IcAdi;
      OpOri, OpLhi:               iclass = IcOri;
      OpLwd:                      iclass = IcLwd;
      OpSwd:                      iclass = IcSwd;
      OpJmp:                      iclass = IcJmp;
      OpJal:                      iclass = IcJal;
      OpAlu: begin
        if (fn_q <= FnShr)       iclass = IcRtype;
        else if (fn_q == FnJpr)  iclass = IcJpr;
        else if (fn_q == FnJrl)  iclass = IcJrl;
        else if (fn_q == FnWwd)  iclass = IcWwd;
        else if (fn_q == FnHlt)  iclass = IcHlt;
        else                     iclass = IcNop;
      end
      default:                    iclass = IcNop;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIf;
      op_q    <= 4'd0;
      fn_q    <= 6'd0;
    end else begin
      case (state_q)
        StIf: begin
          if (bus.input_ready) begin
            op_q    <= bus.opcode;
            fn_q    <= bus.funct;
            state_q <= StId;
          end
        end
        StId: begin
          case (iclass)
            IcJmp, IcJal, IcNop: state_q <= StIf;
            IcHlt:               state_q <= StHalt;
            default:             state_q <= StEx;
          endcase
        end
        StEx: begin
          case (iclass)
            IcRtype, IcAdi, IcOri: state_q <= StWb;
            IcLwd, IcSwd:          state_q <= StMem;
            default:               state_q <= StIf;
          endcase
        end
        StMem: begin
          if (bus.input_ready) state_q <= (iclass == IcLwd) ? StWb : StIf;
        end
        StWb:    state_q <= StIf;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIf;
      endcase
    end
  end

  // Outputs decode from state + latched IR; the reset_n gate keeps every strobe low during reset
  // even though the state register already sits in IF.
  always_comb begin
    bus.ALUOp         = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'd0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'd0;
    bus.mem_to_reg    = 2'd0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.output_valid  = 1'b0;
    if (reset_n) begin
      case (state_q)
        StIf: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.input_ready;
        end
        StId: begin
          bus.ALUOp     = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_b = 2'd1;
          if (iclass == IcJmp || iclass == IcJal) bus.pc_source = 2'd2;
          if (iclass == IcJal) begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 2'd2;
            bus.mem_to_reg = 2'd2;
          end
        end
        StEx: begin
          bus.ALUOp = 1'b1;
          case (iclass)
            IcRtype: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd0;
            end
            IcAdi, IcLwd, IcSwd: bus.alu_src_b = 2'd2;
            IcOri:               bus.alu_src_b = 2'd3;
            IcBranch: begin
              bus.pc_write_cond = 1'b1;
              bus.pc_source     = 2'd1;
            end
            IcJpr, IcJrl: begin
              bus.pc_source = 2'd3;
              bus.pc_write  = 1'b1;
              if (iclass == IcJrl) begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'd2;
                bus.mem_to_reg = 2'd2;
              end
            end
            IcWwd:   bus.output_valid = 1'b1;
            default: ;
          endcase
        end
        StMem: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (iclass == IcLwd);
          bus.mem_write = (iclass == IcSwd);
        end
        StWb: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (iclass == IcLwd) ? 2'd1 : 2'd0;
          bus.reg_dst    = (iclass == IcRtype) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.is_halted = (state_q == StHalt);

`ifdef CTRL_INST_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // Each instruction retires in exactly one cycle; HLT never does.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StId:    retire = (iclass == IcJmp) || (iclass == IcJal) || (iclass == IcNop);
      StEx:    retire = (iclass == IcBranch) || (iclass == IcJpr) || (iclass == IcJrl) ||
                        (iclass == IcWwd);
      StMem:   retire = bus.input_ready && (iclass == IcSwd);
      StWb:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.num_inst = cnt_q;
`else
  assign bus.num_inst = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// tb_multi_cycle_control_fsm: directed bench for multi_cycle_control_fsm.
// Control outputs are packed into one word, compared per cycle against hand-built constants.
module tb_multi_cycle_control_fsm;

`ifdef CTRL_INST_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  // Word layout: ALUOp pc_write pc_write_cond pc_source[2] i_or_d mem_read mem_write ir_write
  //              reg_write reg_dst[2] mem_to_reg[2] alu_src_a alu_src_b[2] output_valid
  localparam logic [17:0] ZERO    = 18'b0_0_0_00_0_0_0_0_0_00_00_0_00_0;
  localparam logic [17:0] IF_WAIT = 18'b0_0_0_00_0_1_0_0_0_00_00_0_00_0;
  localparam logic [17:0] IF_RDY  = 18'b0_0_0_00_0_1_0_1_0_00_00_0_00_0;
  localparam logic [17:0] ID_GEN  = 18'b1_1_0_00_0_0_0_0_0_00_00_0_01_0;
  localparam logic [17:0] ID_JMP  = 18'b1_1_0_10_0_0_0_0_0_00_00_0_01_0;
  localparam logic [17:0] ID_JAL  = 18'b1_1_0_10_0_0_0_0_1_10_10_0_01_0;
  localparam logic [17:0] EX_R    = 18'b1_0_0_00_0_0_0_0_0_00_00_1_00_0;
  localparam logic [17:0] EX_SEXT = 18'b1_0_0_00_0_0_0_0_0_00_00_0_10_0;
  localparam logic [17:0] EX_ZEXT = 18'b1_0_0_00_0_0_0_0_0_00_00_0_11_0;
  localparam logic [17:0] EX_BR   = 18'b1_0_1_01_0_0_0_0_0_00_00_0_00_0;
  localparam logic [17:0] EX_JPR  = 18'b1_1_0_11_0_0_0_0_0_00_00_0_00_0;
  localparam logic [17:0] EX_JRL  = 18'b1_1_0_11_0_0_0_0_1_10_10_0_00_0;
  localparam logic [17:0] EX_WWD  = 18'b1_0_0_00_0_0_0_0_0_00_00_0_00_1;
  localparam logic [17:0] MEM_LWD = 18'b0_0_0_00_1_1_0_0_0_00_00_0_00_0;
  localparam logic [17:0] MEM_SWD = 18'b0_0_0_00_1_0_1_0_0_00_00_0_00_0;
  localparam logic [17:0] WB_R    = 18'b0_0_0_00_0_0_0_0_1_01_00_0_00_0;
  localparam logic [17:0] WB_LWD  = 18'b0_0_0_00_0_0_0_0_1_00_01_0_00_0;
  localparam logic [17:0] WB_I    = 18'b0_0_0_00_0_0_0_0_1_00_00_0_00_0;

  typedef struct packed {
    logic [3:0]       op;
    logic [5:0]       fn;
    logic [2:0]       n;
    logic [4:0][17:0] ew;  // ew[i] = expected word in cycle i
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [17:0] ctl;
  int          checks;
  int          failures;
  logic [15:0] exp_cnt;
  int          ov_count;

  multi_cycle_control_fsm_if #(.CNT_W(16)) bus ();

  multi_cycle_control_fsm #(.CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign ctl = {bus.ALUOp, bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.output_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.output_valid === 1'b1) ov_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [15:0] exp_num();
    return CountEn ? exp_cnt : 16'd0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.opcode = 4'd15;
    bus.funct = 6'd0;
    bus.input_ready = 1'b1;
    #2;
    checks++;
    if (ctl !== ZERO) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, ZERO);
    end
    checks++;
    if (bus.is_halted !== 1'b0 || bus.num_inst !== 16'd0) begin
      failures++; $display("FAIL reset_state halted=%b num=%0d exp 0/0", bus.is_halted,
                           bus.num_inst);
    end
    @(negedge clk);
    @(negedge clk);
    bus.input_ready = 1'b0;
    reset_n = 1'b1;
    exp_cnt = 16'd0;
    #1;
    checks++;
    if (ctl !== IF_WAIT) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", ctl, IF_WAIT);
    end
  endtask

  task automatic test_decode_table();
    vec_t tbl [13];
    tbl[0]  = '{op: 4'd15, fn: 6'd0,  n: 3'd4, ew: {ZERO, WB_R, EX_R, ID_GEN, IF_RDY}};
    tbl[1]  = '{op: 4'd15, fn: 6'd7,  n: 3'd4, ew: {ZERO, WB_R, EX_R, ID_GEN, IF_RDY}};
    tbl[2]  = '{op: 4'd4,  fn: 6'd3,  n: 3'd4, ew: {ZERO, WB_I, EX_SEXT, ID_GEN, IF_RDY}};
    tbl[3]  = '{op: 4'd5,  fn: 6'd0,  n: 3'd4, ew: {ZERO, WB_I, EX_ZEXT, ID_GEN, IF_RDY}};
    tbl[4]  = '{op: 4'd6,  fn: 6'd0,  n: 3'd4, ew: {ZERO, WB_I, EX_ZEXT, ID_GEN, IF_RDY}};
    tbl[5]  = '{op: 4'd1,  fn: 6'd0,  n: 3'd3, ew: {ZERO, ZERO, EX_BR, ID_GEN, IF_RDY}};
    tbl[6]  = '{op: 4'd3,  fn: 6'd0,  n: 3'd3, ew: {ZERO, ZERO, EX_BR, ID_GEN, IF_RDY}};
    tbl[7]  = '{op: 4'd9,  fn: 6'd0,  n: 3'd2, ew: {ZERO, ZERO, ZERO, ID_JMP, IF_RDY}};
    tbl[8]  = '{op: 4'd10, fn: 6'd0,  n: 3'd2, ew: {ZERO, ZERO, ZERO, ID_JAL, IF_RDY}};
    tbl[9]  = '{op: 4'd15, fn: 6'd25, n: 3'd3, ew: {ZERO, ZERO, EX_JPR, ID_GEN, IF_RDY}};
    tbl[10] = '{op: 4'd15, fn: 6'd26, n: 3'd3, ew: {ZERO, ZERO, EX_JRL, ID_GEN, IF_RDY}};
    tbl[11] = '{op: 4'd12, fn: 6'd0,  n: 3'd2, ew: {ZERO, ZERO, ZERO, ID_GEN, IF_RDY}};
    tbl[12] = '{op: 4'd15, fn: 6'd20, n: 3'd2, ew: {ZERO, ZERO, ZERO, ID_GEN, IF_RDY}};
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < int'(tbl[k].n); i++) begin
        @(negedge clk);
        // Scramble the fields once latched: the in-flight instruction must not follow them.
        bus.opcode = (i == 0) ? tbl[k].op : ~tbl[k].op;
        bus.funct = (i == 0) ? tbl[k].fn : ~tbl[k].fn;
        bus.input_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== tbl[k].ew[i]) begin
          failures++;
          $display("FAIL decode op=%0d fn=%0d cyc%0d got=%b exp=%b", tbl[k].op, tbl[k].fn, i,
                   ctl, tbl[k].ew[i]);
        end
        if (i == 0) begin
          checks++;
          if (bus.num_inst !== exp_num()) begin
            failures++; $display("FAIL decode_count entry%0d got=%0d exp=%0d", k,
                                 bus.num_inst, exp_num());
          end
        end
      end
      exp_cnt++;
    end
    @(negedge clk);
    bus.input_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== IF_WAIT || bus.num_inst !== exp_num()) begin
      failures++; $display("FAIL decode_end ctl=%b num=%0d exp=%b/%0d", ctl, bus.num_inst,
                           IF_WAIT, exp_num());
    end
  endtask

  task automatic test_lwd_wait();
    logic [17:0] ew [8];
    logic        rdy [8];
    ew  = '{IF_RDY, ID_GEN, EX_SEXT, MEM_LWD, MEM_LWD, MEM_LWD, MEM_LWD, WB_LWD};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.opcode = 4'd7;
    bus.funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.input_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== ew[i]) begin
        failures++; $display("FAIL lwd_wait cyc%0d got=%b exp=%b", i, ctl, ew[i]);
      end
    end
    exp_cnt++;
    @(negedge clk);
    bus.input_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== IF_WAIT || bus.num_inst !== exp_num()) begin
      failures++; $display("FAIL lwd_end ctl=%b num=%0d exp=%b/%0d", ctl, bus.num_inst,
                           IF_WAIT, exp_num());
    end
  endtask

  task automatic test_swd_wait();
    logic [17:0] ew [6];
    logic        rdy [6];
    ew  = '{IF_WAIT, IF_RDY, ID_GEN, EX_SEXT, MEM_SWD, MEM_SWD};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.opcode = 4'd8;
    bus.funct = 6'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.input_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== ew[i]) begin
        failures++; $display("FAIL swd_wait cyc%0d got=%b exp=%b", i, ctl, ew[i]);
      end
    end
    checks++;
    if (bus.num_inst !== exp_num()) begin
      failures++; $display("FAIL swd_pre_retire got=%0d exp=%0d", bus.num_inst, exp_num());
    end
    exp_cnt++;
    @(negedge clk);
    bus.input_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== IF_WAIT || bus.num_inst !== exp_num()) begin
      failures++; $display("FAIL swd_end ctl=%b num=%0d exp=%b/%0d", ctl, bus.num_inst,
                           IF_WAIT, exp_num());
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [17:0] ew [4];
    ew = '{IF_RDY, ID_GEN, EX_SEXT, MEM_LWD};
    bus.opcode = 4'd7;
    bus.funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.input_ready = (i < 3);
      #1;
      checks++;
      if (ctl !== ew[i]) begin
        failures++; $display("FAIL rst_mem_setup cyc%0d got=%b exp=%b", i, ctl, ew[i]);
      end
    end
    reset_n = 1'b0;
    exp_cnt = 16'd0;
    #1;
    checks++;
    if (ctl !== ZERO || bus.num_inst !== 16'd0) begin
      failures++; $display("FAIL rst_mem_async ctl=%b num=%0d exp=%b/0", ctl, bus.num_inst,
                           ZERO);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ctl !== ZERO) begin
      failures++; $display("FAIL rst_mem_hold got=%b exp=%b", ctl, ZERO);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (ctl !== IF_WAIT) begin
      failures++; $display("FAIL rst_mem_release got=%b exp=%b", ctl, IF_WAIT);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== IF_WAIT || bus.num_inst !== 16'd0) begin
      failures++; $display("FAIL rst_mem_idle ctl=%b num=%0d exp=%b/0", ctl, bus.num_inst,
                           IF_WAIT);
    end
  endtask

  task automatic test_wwd_halt();
    logic [17:0] ew [11];
    int          ov_base;
    ew = '{IF_RDY, ID_GEN, EX_WWD, IF_RDY, ID_GEN, EX_WWD, IF_RDY, ID_GEN, EX_WWD,
           IF_RDY, ID_GEN};
    ov_base = ov_count;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.opcode = 4'd15;
      bus.funct = (i < 9) ? 6'd28 : 6'd29;
      bus.input_ready = 1'b1;
      #1;
      checks++;
      if (ctl !== ew[i]) begin
        failures++; $display("FAIL wwd_halt cyc%0d got=%b exp=%b", i, ctl, ew[i]);
      end
      if (i == 2 || i == 5 || i == 8) exp_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.input_ready = i[0];
      #1;
      checks++;
      if (ctl !== ZERO || bus.is_halted !== 1'b1 || bus.num_inst !== exp_num()) begin
        failures++;
        $display("FAIL halted cyc%0d ctl=%b halt=%b num=%0d exp=%b/1/%0d", i, ctl,
                 bus.is_halted, bus.num_inst, ZERO, exp_num());
      end
    end
    checks++;
    if (ov_count - ov_base !== 3) begin
      failures++; $display("FAIL wwd_pulses got=%0d exp=3", ov_count - ov_base);
    end
    @(negedge clk);
    reset_n = 1'b0;
    bus.input_ready = 1'b0;
    exp_cnt = 16'd0;
    #1;
    checks++;
    if (bus.is_halted !== 1'b0 || ctl !== ZERO) begin
      failures++; $display("FAIL halt_reset halt=%b ctl=%b exp 0/%b", bus.is_halted, ctl, ZERO);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (ctl !== IF_WAIT) begin
      failures++; $display("FAIL halt_exit got=%b exp=%b", ctl, IF_WAIT);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 16'd0;
    ov_count = 0;
    test_reset();
    test_decode_table();
    test_lwd_wait();
    test_swd_wait();
    test_reset_mid_mem();
    test_wwd_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
